// File: rtl/round_phase_counter.sv
// round_phase_counter: round/phase sequencer for the threshold-implemented
// Midori64 datapath. A run steps NUM_ROUNDS rounds of PHASES cycles each,
// pulses done once, then returns to IDLE. It never free-runs.
//
// Optional feature: define ROUND_PHASE_PAUSE_EN to add a 'pause' input that
// freezes the sequence while in RUN.
//
// Control semantics: start is sampled only in IDLE and abort only in RUN.
// There is no ready/back-pressure path. A start seen in IDLE is always taken.
module round_phase_counter #(
    parameter  int ROUND_W    = 5,
    parameter  int NUM_ROUNDS = 16,
    parameter  int PHASES     = 2,
    localparam int PHASE_W    = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
`ifdef ROUND_PHASE_PAUSE_EN
    input  logic               pause,
`endif
    output logic [ROUND_W-1:0] round_counter,
    output logic [PHASE_W-1:0] phase,
    output logic               round_last,
    output logic               phase_last,
    output logic               busy,
    output logic               done
);

    // Reject configurations that could not count to the terminal round.
    if (NUM_ROUNDS < 1) begin : g_bad_rounds_min
        $error("round_phase_counter: NUM_ROUNDS must be >= 1");
    end
    if (NUM_ROUNDS > (2 ** ROUND_W)) begin : g_bad_rounds_max
        $error("round_phase_counter: NUM_ROUNDS exceeds 2**ROUND_W");
    end
    if (PHASES < 1) begin : g_bad_phases
        $error("round_phase_counter: PHASES must be >= 1");
    end

    localparam logic [ROUND_W-1:0] ROUND_MAX = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(PHASES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   hold;

`ifdef ROUND_PHASE_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Sequencer: state plus round/phase counters. Counters saturate at the
    // terminal count and keep their values in IDLE until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            round_counter <= '0;
            phase         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RUN;
                        round_counter <= '0;
                        phase         <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state         <= IDLE;
                        round_counter <= '0;
                        phase         <= '0;
                    end else if (!hold) begin
                        if (phase == PHASE_MAX) begin
                            if (round_counter == ROUND_MAX) begin
                                state <= DONE;
                            end else begin
                                phase         <= '0;
                                round_counter <= round_counter + ROUND_W'(1);
                            end
                        end else begin
                            phase <= phase + PHASE_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags decoded purely from the registered state and counters.
    always_comb begin
        busy       = (state == RUN);
        done       = (state == DONE);
        round_last = (state == RUN) && (round_counter == ROUND_MAX);
        phase_last = (state == RUN) && (phase == PHASE_MAX);
    end

endmodule
